// File: rtl/serial_adder_if.sv
// ============================================================================
// Module   : serial_adder_if
// Brief    : Start/done handshake and operand/result bus for serial_adder.
//            The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output sum, cout, ovf, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial LSB-first adder, one full-adder cell plus a registered
//            carry. SERIAL_ADDER_SUB_EN adds a subtract mode (a - b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sh, w_a_sh_nxt;
  logic [WIDTH-1:0] r_b_sh, w_b_sh_nxt;
  logic [WIDTH-1:0] r_sum, w_sum_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic             w_s;
  logic             w_c;

  assign w_s = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

  always_comb begin
    w_state_nxt = r_state;
    w_a_sh_nxt  = r_a_sh;
    w_b_sh_nxt  = r_b_sh;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_cout_nxt  = r_cout;
    w_ovf_nxt   = r_ovf;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_sh_nxt  = bus.a;
          w_b_sh_nxt  = bus.b;
          w_carry_nxt = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert b and force the carry-in.
          if (bus.sub) begin
            w_b_sh_nxt  = ~bus.b;
            w_carry_nxt = 1'b1;
          end
`endif
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        w_a_sh_nxt  = r_a_sh >> 1;
        w_b_sh_nxt  = r_b_sh >> 1;
        w_sum_nxt   = {w_s, r_sum[WIDTH-1:1]};
        w_carry_nxt = w_c;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == C_CNT_LAST) begin
          // r_carry is the carry into the MSB, w_c the carry out of it.
          w_cout_nxt  = w_c;
          w_ovf_nxt   = r_carry ^ w_c;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_sh  <= w_a_sh_nxt;
      r_b_sh  <= w_b_sh_nxt;
      r_sum   <= w_sum_nxt;
      r_cnt   <= w_cnt_nxt;
      r_carry <= w_carry_nxt;
      r_cout  <= w_cout_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire
